// File: rtl/riscv_mem_arbiter.sv
// Round-robin IF/LS arbiter onto one single-port memory, one outstanding txn.
// Optional response watchdog with mem_err: define ARB_TIMEOUT_EN.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_TIMEOUT_EN
  ,output logic               mem_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t state;
  logic owner;
  logic last;

  logic pick_ls;
  logic accept;
  logic done;
  logic to_hit;
  logic [DATA_W-1:0] rsp_data;

  // LS wins only when alone or when IF was served last
  assign pick_ls = ls_req && (!if_req || last == OWN_IF);
  assign accept  = (state == REQ) && mem_gnt;
  assign done    = (state == RSP) && (mem_rvalid || to_hit);

  assign if_gnt    = accept && owner == OWN_IF;
  assign ls_gnt    = accept && owner == OWN_LS;
  assign if_rvalid = done && owner == OWN_IF;
  assign ls_rvalid = done && owner == OWN_LS;
  assign if_rdata  = if_rvalid ? rsp_data : '0;
  assign ls_rdata  = ls_rvalid ? rsp_data : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  assign to_hit = (state == RSP) && !mem_rvalid &&
                  cnt == CNT_W'(TIMEOUT - 1);
  assign mem_err  = to_hit;
  assign rsp_data = to_hit ? DATA_W'(32'hDEADBEEF) : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != RSP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign to_hit   = 1'b0;
  assign rsp_data = mem_rdata;

  if (TIMEOUT > 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      last      <= OWN_LS;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state   <= REQ;
            mem_req <= 1'b1;
            owner   <= pick_ls;
            if (pick_ls) begin
              mem_we    <= ls_we;
              mem_be    <= ls_be;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= RSP;
            mem_req <= 1'b0;
            last    <= owner;
          end
        end
        RSP: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
